// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Round-robin arbiter sharing one single-port word RAM between a
//            CPU data port (m0) and a debug/loader port (m1). Converts byte
//            addresses to word indices, rejects out-of-range addresses and
//            illegal write masks, and answers every accepted request with a
//            registered one-cycle response pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          DEPTH     = 16384,
  parameter int          ADDR_W    = 14
) (
  input  logic              clk,
  input  logic              rst,
  // port 0: CPU data path
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [31:0]       m0_addr,
  input  logic              m0_wen,
  input  logic [3:0]        m0_wmask,
  input  logic [31:0]       m0_wdata,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  // port 1: debug / program loader
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [31:0]       m1_addr,
  input  logic              m1_wen,
  input  logic [3:0]        m1_wmask,
  input  logic [31:0]       m1_wdata,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  // RAM pins
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_op,
  output logic [3:0]        ram_mask,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  localparam logic [31:0] DEPTH_WORDS = 32'(DEPTH);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        m0_rvalid_q, m0_rvalid_d;
  logic        m0_err_q, m0_err_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic        m1_rvalid_q, m1_rvalid_d;
  logic        m1_err_q, m1_err_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        sel;        // 0 = port 0 granted, 1 = port 1 granted
  logic        hs;         // handshake happens this cycle
  logic [31:0] req_addr;
  logic        req_wen;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic [31:0] byte_off;
  logic [31:0] word_off;
  logic        below_base;
  logic        above_top;
  logic        mask_ok;
  logic        req_err;
  logic [31:0] resp_data;

  // Pick the winner: sole requester, or the port that did not win last time.
  // Reset blocks the handshake so nothing is accepted while rst is high.
  always_comb begin
    if (m0_valid && m1_valid) begin
      sel = ~last_grant_q;
    end else begin
      sel = m1_valid;
    end
    hs       = (state_q == S_IDLE) && (m0_valid || m1_valid) && !rst;
    m0_ready = hs && !sel;
    m1_ready = hs && sel;
  end

  // Route the granted port's request fields and validate them.
  always_comb begin
    req_addr   = sel ? m1_addr  : m0_addr;
    req_wen    = sel ? m1_wen   : m0_wen;
    req_wmask  = sel ? m1_wmask : m0_wmask;
    req_wdata  = sel ? m1_wdata : m0_wdata;
    // 32-bit unsigned offset; a borrow (addr below base) is flagged separately
    byte_off   = req_addr - ADDR_BASE;
    word_off   = byte_off >> 2;
    below_base = req_addr < ADDR_BASE;
    above_top  = word_off >= DEPTH_WORDS;
    case (req_wmask)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: mask_ok = 1'b1;
      default:                            mask_ok = 1'b0;
    endcase
    req_err    = below_base || above_top || (req_wen && !mask_ok);
    // writes and rejected requests return zero data
    resp_data  = (req_wen || req_err) ? 32'h0 : ram_rdata;
  end

  // Drive the RAM only during the handshake cycle; idle value is all zeros.
  always_comb begin
    ram_addr  = '0;
    ram_op    = 1'b0;
    ram_mask  = 4'h0;
    ram_wdata = 32'h0;
    if (hs) begin
      ram_addr  = word_off[ADDR_W-1:0];
      ram_op    = req_wen && !req_err;
      ram_mask  = req_wmask;
      ram_wdata = req_wdata;
    end
  end

  // Next-state and response-register computation for the IDLE/RESP FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m0_rvalid_d  = 1'b0;
    m0_err_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rvalid_d  = 1'b0;
    m1_err_d     = 1'b0;
    m1_rdata_d   = m1_rdata_q;
    if (state_q == S_IDLE) begin
      if (hs) begin
        state_d      = S_RESP;
        last_grant_d = sel;
        if (!sel) begin
          m0_rvalid_d = 1'b1;
          m0_err_d    = req_err;
          m0_rdata_d  = resp_data;
        end else begin
          m1_rvalid_d = 1'b1;
          m1_err_d    = req_err;
          m1_rdata_d  = resp_data;
        end
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  // State and response registers; port 0 wins the first contest after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      m0_rvalid_q  <= 1'b0;
      m0_err_q     <= 1'b0;
      m0_rdata_q   <= 32'h0;
      m1_rvalid_q  <= 1'b0;
      m1_err_q     <= 1'b0;
      m1_rdata_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m0_err_q     <= m0_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rvalid_q  <= m1_rvalid_d;
      m1_err_q     <= m1_err_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // A reset landing in the response cycle cancels the pending pulse.
  always_comb begin
    m0_rvalid = m0_rvalid_q && !rst;
    m0_err    = m0_err_q && !rst;
    m0_rdata  = m0_rdata_q;
    m1_rvalid = m1_rvalid_q && !rst;
    m1_err    = m1_err_q && !rst;
    m1_rdata  = m1_rdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Directed self-checking bench for ram_arbiter with a behavioural
//            asynchronous-read word RAM attached to the RAM pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_valid, m0_ready, m0_wen, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wmask;
  logic        m1_valid, m1_ready, m1_wen, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wmask;
  logic [13:0] ram_addr;
  logic        ram_op;
  logic [3:0]  ram_mask;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:16383];
  logic [31:0] lane_mask;

  ram_arbiter #(
    .ADDR_BASE(32'h0000_0000),
    .DEPTH    (16384),
    .ADDR_W   (14)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .m0_addr  (m0_addr),
    .m0_wen   (m0_wen),
    .m0_wmask (m0_wmask),
    .m0_wdata (m0_wdata),
    .m0_rvalid(m0_rvalid),
    .m0_rdata (m0_rdata),
    .m0_err   (m0_err),
    .m1_valid (m1_valid),
    .m1_ready (m1_ready),
    .m1_addr  (m1_addr),
    .m1_wen   (m1_wen),
    .m1_wmask (m1_wmask),
    .m1_wdata (m1_wdata),
    .m1_rvalid(m1_rvalid),
    .m1_rdata (m1_rdata),
    .m1_err   (m1_err),
    .ram_addr (ram_addr),
    .ram_op   (ram_op),
    .ram_mask (ram_mask),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: asynchronous read, byte-masked write on the clock edge
  assign ram_rdata = mem[ram_addr];
  assign lane_mask = {{8{ram_mask[3]}}, {8{ram_mask[2]}}, {8{ram_mask[1]}}, {8{ram_mask[0]}}};
  always @(posedge clk) begin
    if (ram_op) mem[ram_addr] <= (mem[ram_addr] & ~lane_mask) | (ram_wdata & lane_mask);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drv0(input logic v, input logic [31:0] a, input logic w,
                      input logic [3:0] m, input logic [31:0] d);
    m0_valid = v; m0_addr = a; m0_wen = w; m0_wmask = m; m0_wdata = d;
  endtask

  task automatic drv1(input logic v, input logic [31:0] a, input logic w,
                      input logic [3:0] m, input logic [31:0] d);
    m1_valid = v; m1_addr = a; m1_wen = w; m1_wmask = m; m1_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    rst = 1'b1;
    drv0(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drv1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step();
    step();

    // reset state
    chk("rst_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    chk("rst_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_m0_err", {31'h0, m0_err}, 32'h0);
    chk("rst_ram_op", {31'h0, ram_op}, 32'h0);
    rst = 1'b0;

    // 1: m0 full-word write to 0x10
    drv0(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
    #1;
    chk("t1_m0_ready", {31'h0, m0_ready}, 32'h1);
    chk("t1_m1_ready", {31'h0, m1_ready}, 32'h0);
    chk("t1_ram_addr", {18'h0, ram_addr}, 32'h4);
    chk("t1_ram_op", {31'h0, ram_op}, 32'h1);
    chk("t1_ram_mask", {28'h0, ram_mask}, 32'hF);
    chk("t1_ram_wdata", ram_wdata, 32'hDEADBEEF);
    step();
    chk("t1_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("t1_m0_err", {31'h0, m0_err}, 32'h0);
    chk("t1_m0_rdata", m0_rdata, 32'h0);
    chk("t1_resp_ready", {31'h0, m0_ready}, 32'h0);
    m0_valid = 1'b0;
    step();
    chk("t1_rvalid_pulse", {31'h0, m0_rvalid}, 32'h0);

    // 2: m0 reads back, m1 writes upper half-word, m1 reads merged word
    drv0(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
    #1;
    chk("t2_rd_ram_op", {31'h0, ram_op}, 32'h0);
    chk("t2_rd_ram_addr", {18'h0, ram_addr}, 32'h4);
    step();
    chk("t2_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("t2_m0_rdata", m0_rdata, 32'hDEADBEEF);
    m0_valid = 1'b0;
    step();
    drv1(1'b1, 32'h12, 1'b1, 4'hC, 32'h12340000);
    #1;
    chk("t2_m1_ready", {31'h0, m1_ready}, 32'h1);
    chk("t2_wr_ram_op", {31'h0, ram_op}, 32'h1);
    chk("t2_wr_ram_addr", {18'h0, ram_addr}, 32'h4);
    chk("t2_wr_ram_mask", {28'h0, ram_mask}, 32'hC);
    step();
    chk("t2_m1_wr_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("t2_m1_wr_err", {31'h0, m1_err}, 32'h0);
    m1_valid = 1'b0;
    step();
    drv1(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
    step();
    chk("t2_m1_rdata", m1_rdata, 32'h1234BEEF);
    chk("t2_m0_rdata_hold", m0_rdata, 32'hDEADBEEF);
    m1_valid = 1'b0;
    step();

    // 3: both ports request continuously; grants alternate m0, m1
    drv0(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
    drv1(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("t3_m0_ready_c%0d", i), {31'h0, m0_ready}, {31'h0, (i % 4) == 0});
      chk($sformatf("t3_m1_ready_c%0d", i), {31'h0, m1_ready}, {31'h0, (i % 4) == 2});
      chk($sformatf("t3_m0_rvalid_c%0d", i), {31'h0, m0_rvalid}, {31'h0, (i % 4) == 1});
      chk($sformatf("t3_m1_rvalid_c%0d", i), {31'h0, m1_rvalid}, {31'h0, (i % 4) == 3});
      chk($sformatf("t3_both_ready_c%0d", i), {31'h0, m0_ready & m1_ready}, 32'h0);
      step();
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    step();

    // 4: illegal mask write, out-of-range read, last legal word
    drv1(1'b1, 32'h10, 1'b1, 4'b0101, 32'hFFFFFFFF);
    #1;
    chk("t4_m1_ready", {31'h0, m1_ready}, 32'h1);
    chk("t4_badmask_ram_op", {31'h0, ram_op}, 32'h0);
    step();
    chk("t4_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("t4_m1_err", {31'h0, m1_err}, 32'h1);
    chk("t4_m1_rdata", m1_rdata, 32'h0);
    m1_valid = 1'b0;
    step();
    drv0(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
    step();
    chk("t4_unchanged_rdata", m0_rdata, 32'h1234BEEF);
    chk("t4_unchanged_err", {31'h0, m0_err}, 32'h0);
    m0_valid = 1'b0;
    step();
    drv0(1'b1, 32'h0001_0000, 1'b0, 4'h0, 32'h0);
    #1;
    chk("t4_oor_ram_op", {31'h0, ram_op}, 32'h0);
    step();
    chk("t4_oor_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("t4_oor_err", {31'h0, m0_err}, 32'h1);
    chk("t4_oor_rdata", m0_rdata, 32'h0);
    m0_valid = 1'b0;
    step();
    drv0(1'b1, 32'h0000_FFFC, 1'b0, 4'h0, 32'h0);
    #1;
    chk("t4_top_ram_addr", {18'h0, ram_addr}, 32'h3FFF);
    step();
    chk("t4_top_err", {31'h0, m0_err}, 32'h0);
    m0_valid = 1'b0;
    step();

    // 5: reset during response cycle suppresses rvalid, m0 wins next contest
    drv0(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
    step();
    rst = 1'b1;
    #1;
    chk("t5_rvalid_suppressed", {31'h0, m0_rvalid}, 32'h0);
    chk("t5_err_suppressed", {31'h0, m0_err}, 32'h0);
    step();
    rst = 1'b0;
    drv1(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
    #1;
    chk("t5_m0_wins", {31'h0, m0_ready}, 32'h1);
    chk("t5_m1_loses", {31'h0, m1_ready}, 32'h0);
    step();
    chk("t5_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("t5_m0_rdata", m0_rdata, 32'h1234BEEF);
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    step();
    drv0(1'b1, 32'h20, 1'b1, 4'hF, 32'h55555555);
    rst = 1'b1;
    #1;
    chk("t5_rst_no_ready", {31'h0, m0_ready}, 32'h0);
    chk("t5_rst_no_ram_op", {31'h0, ram_op}, 32'h0);
    step();
    rst = 1'b0;
    m0_valid = 1'b0;
    step();

    // 6: m1 request raised during RESP and dropped is ignored
    drv0(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
    step();
    m0_valid = 1'b0;
    drv1(1'b1, 32'h20, 1'b1, 4'hF, 32'hAAAAAAAA);
    #1;
    chk("t6_resp_m1_ready", {31'h0, m1_ready}, 32'h0);
    chk("t6_resp_ram_op", {31'h0, ram_op}, 32'h0);
    step();
    m1_valid = 1'b0;
    #1;
    chk("t6_idle_ram_op", {31'h0, ram_op}, 32'h0);
    chk("t6_idle_m1_ready", {31'h0, m1_ready}, 32'h0);
    step();
    chk("t6_no_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
    drv0(1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
    step();
    chk("t6_word8_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("t6_word8_unwritten", m0_rdata, 32'h0);
    m0_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
